umi_prio_scheduler: RTL

// - 2:1 UMI traffic scheduler: arbitrates response (in0) and request (in1) streams onto one UMI output.
// - Fixed priority with anti-starvation, or round-robin. Result goes into a registered output slot.
// - Sits where request and response traffic share one link. Replaces pure fixed priority so requests are never starved.

---
 rtl/umi_prio_scheduler_if.sv | 33 +++
 rtl/umi_prio_scheduler.sv | 77 +++++++
 2 files changed

// File: rtl/umi_prio_scheduler_if.sv
// UMI handshake bundle for the 2:1 response/request scheduler.
// slave = scheduler side, master = surrounding fabric (sources and sink).
interface umi_prio_scheduler_if #(
    parameter int UW = 256
);
    logic          umi_resp_in_valid;
    logic [UW-1:0] umi_resp_in_packet;
    logic          umi_resp_in_ready;
    logic          umi_req_in_valid;
    logic [UW-1:0] umi_req_in_packet;
    logic          umi_req_in_ready;
    logic          umi_out_valid;
    logic [UW-1:0] umi_out_packet;
    logic          umi_out_ready;

    modport slave (
        input  umi_resp_in_valid, umi_resp_in_packet,
        output umi_resp_in_ready,
        input  umi_req_in_valid, umi_req_in_packet,
        output umi_req_in_ready,
        output umi_out_valid, umi_out_packet,
        input  umi_out_ready
    );

    modport master (
        output umi_resp_in_valid, umi_resp_in_packet,
        input  umi_resp_in_ready,
        output umi_req_in_valid, umi_req_in_packet,
        input  umi_req_in_ready,
        input  umi_out_valid, umi_out_packet,
        output umi_out_ready
    );
endinterface

// File: rtl/umi_prio_scheduler.sv
// 2:1 UMI scheduler: response stream (high priority) and request stream share one
// registered output slot; fixed priority with anti-starvation, or round-robin.
module umi_prio_scheduler #(
    parameter int UW = 256,
    parameter int CW = 8,
    parameter int SW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_mode,
    input  logic [CW-1:0]        cfg_starve_max,
    umi_prio_scheduler_if.slave  umi,
    output logic [SW-1:0]        stat_forced
);
    localparam logic GRANT_RESP = 1'b0;
    localparam logic GRANT_REQ  = 1'b1;

    logic          resp_valid;
    logic          req_valid;
    logic          space;
    logic          xfer;
    logic          contended;
    logic          starved;
    logic          grant;
    logic          last_grant;
    logic [CW-1:0] starve_cnt;
    logic          out_valid;
    logic [UW-1:0] out_packet;

    assign resp_valid = umi.umi_resp_in_valid;
    assign req_valid  = umi.umi_req_in_valid;

    always_comb begin
        space     = !out_valid || umi.umi_out_ready;
        xfer      = space && (resp_valid || req_valid);
        contended = resp_valid && req_valid;
        starved   = (cfg_starve_max != '0) && (starve_cnt >= cfg_starve_max);
        grant     = GRANT_RESP;
        if (contended) begin
            if (cfg_mode)
                grant = (last_grant == GRANT_REQ) ? GRANT_RESP : GRANT_REQ;
            else if (starved)
                grant = GRANT_REQ;
        end else if (req_valid) begin
            grant = GRANT_REQ;
        end
    end

    assign umi.umi_resp_in_ready = space && (grant == GRANT_RESP);
    assign umi.umi_req_in_ready  = space && (grant == GRANT_REQ);
    assign umi.umi_out_valid     = out_valid;
    assign umi.umi_out_packet    = out_packet;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_packet  <= '0;
            starve_cnt  <= '0;
            stat_forced <= '0;
            last_grant  <= GRANT_REQ;
        end else if (xfer) begin
            out_valid  <= 1'b1;
            out_packet <= (grant == GRANT_REQ) ? umi.umi_req_in_packet : umi.umi_resp_in_packet;
            last_grant <= grant;
            // Fairness history is kept in both modes so a mode switch stays fair.
            if (grant == GRANT_REQ)
                starve_cnt <= '0;
            else if (req_valid && (starve_cnt != '1))
                starve_cnt <= starve_cnt + 1'b1;
            // In mode 0 a contended REQ grant can only come from the starvation rule.
            if ((grant == GRANT_REQ) && contended && !cfg_mode && (stat_forced != '1))
                stat_forced <= stat_forced + 1'b1;
        end else if (umi.umi_out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
